// File: rtl/dice_roller.sv
// Two-dice roller: a button press while enabled animates random faces for
// ROLL_CYCLES cycles, then latches final values and pulses done.
module dice_roller #(
    parameter int unsigned ROLL_CYCLES = 25_000_000,
    parameter int unsigned SHUFFLE_DIV = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       btn,
    output logic [2:0] die_a,
    output logic [2:0] die_b,
    output logic [3:0] sum,
    output logic       rolling,
    output logic       done
);

    // state   | meaning
    // IDLE    | waiting for enable && button rise
    // ROLLING | animating; dice reshuffle every SHUFFLE_DIV cycles
    // HOLD    | final dice shown until enable drops
    typedef enum logic [1:0] {IDLE, ROLLING, HOLD} state_t;

    localparam logic [31:0] ROLL_LOAD = 32'(ROLL_CYCLES - 1);
    localparam logic [31:0] SHUF_LOAD = 32'(SHUFFLE_DIV - 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] shuf_q, shuf_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        btn_q;
    logic [2:0]  die_a_q, die_a_d;
    logic [2:0]  die_b_q, die_b_d;
    logic [3:0]  sum_q, sum_d;
    logic        rolling_q, rolling_d;
    logic        done_q, done_d;

    logic        rise;
    logic        lfsr_fb;
    logic [2:0]  cand_a;
    logic [2:0]  cand_b;

    assign rise    = btn & ~btn_q;
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign lfsr_d  = (lfsr_q == 16'h0000) ? LFSR_SEED : {lfsr_q[14:0], lfsr_fb};
    assign cand_a  = 3'(lfsr_q[7:0] % 8'd6) + 3'd1;
    assign cand_b  = 3'(lfsr_q[15:8] % 8'd6) + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shuf_q    <= '0;
            lfsr_q    <= LFSR_SEED;
            btn_q     <= 1'b1;
            die_a_q   <= 3'd1;
            die_b_q   <= 3'd1;
            sum_q     <= 4'd2;
            rolling_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shuf_q    <= shuf_d;
            lfsr_q    <= lfsr_d;
            btn_q     <= btn;
            die_a_q   <= die_a_d;
            die_b_q   <= die_b_d;
            sum_q     <= sum_d;
            rolling_q <= rolling_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && rise) state_d = ROLLING;
            ROLLING: begin
                if (!enable)            state_d = IDLE;
                else if (cnt_q == '0)   state_d = HOLD;
            end
            HOLD:    if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        shuf_d  = shuf_q;
        die_a_d = die_a_q;
        die_b_d = die_b_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (state_d == ROLLING) begin
                    cnt_d  = ROLL_LOAD;
                    shuf_d = SHUF_LOAD;
                end
            end
            ROLLING: begin
                // Dropping enable freezes the dice exactly as last shown.
                if (enable) begin
                    if (cnt_q == '0) begin
                        die_a_d = cand_a;
                        die_b_d = cand_b;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                        if (shuf_q == '0) begin
                            die_a_d = cand_a;
                            die_b_d = cand_b;
                            shuf_d  = SHUF_LOAD;
                        end else begin
                            shuf_d = shuf_q - 32'd1;
                        end
                    end
                end
            end
            default: ;
        endcase
        sum_d     = {1'b0, die_a_d} + {1'b0, die_b_d};
        rolling_d = (state_d == ROLLING);
    end

    assign die_a   = die_a_q;
    assign die_b   = die_b_q;
    assign sum     = sum_q;
    assign rolling = rolling_q;
    assign done    = done_q;

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller (ROLL_CYCLES=8, SHUFFLE_DIV=2); final dice
// are predicted from a reference LFSR and queued when each press is driven.
module tb_dice_roller;

    localparam int ROLL = 8;
    localparam int DIV  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       btn;
    logic [2:0] die_a;
    logic [2:0] die_b;
    logic [3:0] sum;
    logic       rolling;
    logic       done;

    dice_roller #(.ROLL_CYCLES(ROLL), .SHUFFLE_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .enable(enable), .btn(btn),
        .die_a(die_a), .die_b(die_b), .sum(sum),
        .rolling(rolling), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] a;
        logic [2:0] b;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          roll_lo = 1;
    int          roll_hi = 0;
    int          last_chg = -100;
    bit          chk_en = 1'b0;
    logic [15:0] m_lfsr = 16'hACE1;
    logic [2:0]  prev_a;
    logic [2:0]  prev_b;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        if (v == 16'h0000) return 16'hACE1;
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    function automatic logic [2:0] face(input logic [7:0] v);
        int r;
        r = (int'(v) % 6) + 1;
        return 3'(r);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic monitor();
        bit   exp_roll;
        bit   changed;
        exp_t e;
        exp_roll = (cyc >= roll_lo) && (cyc <= roll_hi);
        changed  = (die_a !== prev_a) || (die_b !== prev_b);
        check("rolling", 16'(rolling), 16'(exp_roll));
        check("sum", 16'(sum), 16'({1'b0, die_a}) + 16'({1'b0, die_b}));
        check("die_a_range", 16'(die_a >= 3'd1 && die_a <= 3'd6), 16'd1);
        check("die_b_range", 16'(die_b >= 3'd1 && die_b <= 3'd6), 16'd1);
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check("done", 16'(done), 16'd1);
            check("final_a", 16'(die_a), 16'(e.a));
            check("final_b", 16'(die_b), 16'(e.b));
        end else begin
            check("done_idle", 16'(done), 16'd0);
            if (!exp_roll) begin
                check("frozen_a", 16'(die_a), 16'(prev_a));
                check("frozen_b", 16'(die_b), 16'(prev_b));
            end
        end
        if (changed) begin
            check("shuffle_gap", 16'(cyc - last_chg >= DIV), 16'd1);
            last_chg = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) m_lfsr = 16'hACE1;
        else     m_lfsr = lfsr_next(m_lfsr);
        cyc++;
        @(negedge clk);
        if (chk_en) monitor();
        prev_a = die_a;
        prev_b = die_b;
    endtask

    // Press in the current cycle T; a completing roll shows its final dice,
    // taken from the LFSR state at T+ROLL, in cycle T+ROLL+1.
    task automatic press(input bit completes, output int t);
        logic [15:0] f;
        t = cyc;
        btn = 1'b1;
        roll_lo = t + 1;
        roll_hi = t + ROLL;
        if (completes) begin
            f = m_lfsr;
            repeat (ROLL) f = lfsr_next(f);
            sb.push_back('{t + ROLL + 1, face(f[7:0]), face(f[15:8])});
        end
        tick();
        btn = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_die_a"}, 16'(die_a), 16'd1);
        check({tag, "_die_b"}, 16'(die_b), 16'd1);
        check({tag, "_sum"}, 16'(sum), 16'd2);
        check({tag, "_rolling"}, 16'(rolling), 16'd0);
        check({tag, "_done"}, 16'(done), 16'd0);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        enable = 1'b0;
        btn = 1'b0;

        // Two reset cycles
        tick();
        check_reset_outputs("rst1");
        tick();
        check_reset_outputs("rst2");
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (3) tick();

        // Press while disabled: nothing happens
        btn = 1'b1;
        tick();
        btn = 1'b0;
        repeat (4) tick();

        // Full roll
        enable = 1'b1;
        repeat (2) tick();
        press(1'b1, t);
        repeat (10) tick();

        // Press in HOLD is ignored
        btn = 1'b1;
        tick();
        btn = 1'b0;
        repeat (5) tick();

        // Leave HOLD, then roll again
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        press(1'b1, t);
        repeat (10) tick();

        // Abort by dropping enable in cycle T+4
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        press(1'b0, t);
        roll_hi = t + 4;
        repeat (3) tick();
        enable = 1'b0;
        repeat (12) tick();
        enable = 1'b1;
        repeat (4) tick();

        // Reset in the middle of a roll
        press(1'b0, t);
        repeat (2) tick();
        rst = 1'b1;
        roll_hi = t + 3;
        chk_en = 1'b0;
        tick();
        check_reset_outputs("rst_roll");
        rst = 1'b0;
        tick();
        check("post_rst_roll_rolling", 16'(rolling), 16'd0);
        check("post_rst_roll_done", 16'(done), 16'd0);
        chk_en = 1'b1;
        repeat (12) tick();

        // Reset in HOLD with the button held through release
        press(1'b1, t);
        repeat (10) tick();
        btn = 1'b1;
        rst = 1'b1;
        chk_en = 1'b0;
        tick();
        check_reset_outputs("rst_hold");
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (4) tick();
        btn = 1'b0;
        tick();
        press(1'b1, t);
        repeat (10) tick();

        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dice_roller.md
DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 SHALL have parameter ROLL_CYCLES, default 25_000_000, meaning the number of clock cycles a roll animates (minimum 1).
REQ-002 SHALL have parameter SHUFFLE_DIV, default 2_500_000, meaning the number of clock cycles between displayed-dice updates while rolling (minimum 1).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port enable, input, 1 bit, high while the game controller is in its ROLL state.
REQ-006 SHALL have port btn, input, 1 bit, the roll button, already synchronized to clk.
REQ-007 SHALL have port die_a, output, 3 bits, the first die value, 1..6.
REQ-008 SHALL have port die_b, output, 3 bits, the second die value, 1..6.
REQ-009 SHALL have port sum, output, 4 bits, equal to die_a+die_b at all times, range 2..12.
REQ-010 SHALL have port rolling, output, 1 bit, high while the animation runs.
REQ-011 SHALL have port done, output, 1 bit, a one-cycle pulse when final dice are valid; it drives the controller's pulse_i.

Function
REQ-012 SHALL register btn into btn_q each cycle; rise = btn & ~btn_q.
REQ-013 SHALL run a free-running 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1, stepping every cycle in all states.
REQ-014 SHALL never let the LFSR reach all-zero; if it does, it reloads 16'hACE1 on the next cycle.
REQ-015 SHALL derive the candidate values as cand_a = (lfsr[7:0] mod 6)+1 and cand_b = (lfsr[15:8] mod 6)+1.
REQ-016 SHALL implement states IDLE, ROLLING and HOLD.
REQ-017 IDLE: when enable && rise in cycle T, SHALL enter ROLLING and load the counter with ROLL_CYCLES-1 at the end of T; otherwise it stays in IDLE.
REQ-018 ROLLING: rolling=1; the counter decrements each cycle; the shuffle counter wraps every SHUFFLE_DIV cycles, and on each wrap die_a/die_b load cand_a/cand_b.
REQ-019 ROLLING: when the counter is 0 and enable=1, SHALL load die_a/die_b from cand_a/cand_b, enter HOLD, and register done=1.
REQ-020 SHALL produce rolling high for exactly cycles T+1..T+ROLL_CYCLES, and done high only in cycle T+ROLL_CYCLES+1.
REQ-021 ROLLING: if enable=0 in any cycle, SHALL return to IDLE next cycle with no done; die_a/die_b keep their last shown values.
REQ-022 HOLD: rolling=0, die values frozen, rise ignored; SHALL enter IDLE when enable=0.
REQ-023 SHALL ignore rise in ROLLING; a press during an animation neither restarts nor extends it.
REQ-024 SHALL register die_a, die_b, sum, rolling and done; there are no combinational input-to-output paths.
REQ-025 SHALL keep done a single-cycle pulse under all input combinations.

Reset
REQ-026 While rst=1 at a clock edge: state=IDLE, die_a=1, die_b=1, sum=2, rolling=0, done=0, LFSR=16'hACE1, both counters=0.
REQ-027 btn_q SHALL reset to 1, so a button held through reset release does not trigger a roll.
REQ-028 Reset mid-ROLLING or in HOLD SHALL abort immediately, with no done pulse.
REQ-029 rst SHALL take priority over all other inputs.

Verification (ROLL_CYCLES=8, SHUFFLE_DIV=2)
REQ-030 Assert rst for 2 cycles -> die_a=1, die_b=1, sum=2, rolling=0, done=0.
REQ-031 enable=1 and btn 0->1 in cycle T -> rolling=1 in T+1..T+8; done=1 only in T+9; die values in 1..6; sum=die_a+die_b; dice change at most every 2 cycles.
REQ-032 enable=0 with a btn press -> rolling and done stay 0 and the dice are unchanged.
REQ-033 enable dropped at T+4 -> rolling=0 from T+5, and done never asserts.
REQ-034 In HOLD, press btn again with enable=1 -> ignored; enable 0 then 1 plus a new press -> a new 8-cycle roll.
REQ-035 btn held at 1 across reset release with enable=1 -> no roll; release then press -> a roll starts.
